// File: rtl/ks_adder_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone adder:
// the generate/propagate pair, its prefix operator and the segment count.
package ks_adder_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  // hi is the more significant group, lo the adjacent lower group.
  function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
    pg_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  function automatic int ks_nseg(input int width, input int reg_every);
    return ($clog2(width) + reg_every - 1) / reg_every;
  endfunction

endpackage

// File: rtl/ks_adder_pipe_seg.sv
// Combinational block of NLVL consecutive Kogge-Stone prefix levels starting at
// level FIRST_LVL. Node 0 is the carry-in position; nodes 1..WIDTH are bits 0..WIDTH-1.
module ks_prefix_seg
  import ks_adder_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FIRST_LVL = 0,
  parameter int NLVL      = 2
) (
  input  pg_t [WIDTH:0] pg_in,
  output pg_t [WIDTH:0] pg_out
);

  pg_t [WIDTH:0] stg [0:NLVL];

  assign stg[0] = pg_in;

  for (genvar gi = 0; gi < NLVL; gi++) begin : g_lvl
    localparam int DIST = 1 << (FIRST_LVL + gi);
    for (genvar gj = 0; gj <= WIDTH; gj++) begin : g_node
      if (gj >= DIST) begin : g_comb
        assign stg[gi+1][gj] = pg_combine(stg[gi][gj], stg[gi][gj-DIST]);
      end else begin : g_pass
        assign stg[gi+1][gj] = stg[gi][gj];
      end
    end
  end

  assign pg_out = stg[NLVL];

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control.
// Define KS_OVERFLOW_EN to add the registered signed-overflow output ovf.
module ks_adder_pipe
  import ks_adder_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 2,
  parameter int TAG_W     = 4,
  localparam int LVLS     = $clog2(WIDTH),
  localparam int NSEG     = ks_nseg(WIDTH, REG_EVERY),
  localparam int CNT_W    = $clog2(NSEG + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [TAG_W-1:0] tag_out,
  output logic [CNT_W-1:0] in_flight
`ifdef KS_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  logic stall, in_xfer, out_xfer;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  logic [WIDTH-1:0] b_eff, p0;
  logic             c0;
  pg_t  [WIDTH:0]   pg0;

  assign b_eff  = op_sub ? ~b : b;
  assign c0     = op_sub | cin;
  assign p0     = a ^ b_eff;
  assign pg0[0] = pg_t'{g: c0, p: 1'b0};
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign pg0[gi+1] = pg_t'{g: a[gi] & b_eff[gi], p: p0[gi]};
  end

  pg_t  [WIDTH:0]   seg_in   [0:NSEG-1];
  pg_t  [WIDTH:0]   seg_out  [0:NSEG-1];
  pg_t  [WIDTH:0]   pg_reg   [0:NSEG-1];
  logic [WIDTH-1:0] p_reg    [0:NSEG-1];
  logic [TAG_W-1:0] tag_reg  [0:NSEG-1];
  logic             valid_reg[0:NSEG-1];
  logic [WIDTH-1:0] p_prev   [0:NSEG-1];
  logic [TAG_W-1:0] tag_prev [0:NSEG-1];
  logic             valid_prev[0:NSEG-1];

  for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
    localparam int FIRST = gi * REG_EVERY;
    localparam int NL    = (LVLS - FIRST < REG_EVERY) ? (LVLS - FIRST) : REG_EVERY;

    if (gi == 0) begin : g_first
      assign seg_in[gi]     = pg0;
      assign p_prev[gi]     = p0;
      assign tag_prev[gi]   = tag_in;
      assign valid_prev[gi] = in_valid;
    end else begin : g_next
      assign seg_in[gi]     = pg_reg[gi-1];
      assign p_prev[gi]     = p_reg[gi-1];
      assign tag_prev[gi]   = tag_reg[gi-1];
      assign valid_prev[gi] = valid_reg[gi-1];
    end

    ks_prefix_seg #(
      .WIDTH    (WIDTH),
      .FIRST_LVL(FIRST),
      .NLVL     (NL)
    ) u_seg (
      .pg_in (seg_in[gi]),
      .pg_out(seg_out[gi])
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_reg[gi] <= 1'b0;
      end else if (!stall) begin
        valid_reg[gi] <= valid_prev[gi];
        pg_reg[gi]    <= seg_out[gi];
        p_reg[gi]     <= p_prev[gi];
        tag_reg[gi]   <= tag_prev[gi];
      end
    end
  end

  // Only the top node can still miss the carry-in position (WIDTH a power of
  // two); nodes already spanning it have p=0, so one extra fold is exact for all.
  pg_t  [WIDTH:0] pg_last;
  logic [WIDTH:0] carry;
  assign pg_last = pg_reg[NSEG-1];
  for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_carry
    assign carry[gi] = pg_last[gi].g | (pg_last[gi].p & pg_last[0].g);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      tag_out   <= '0;
`ifdef KS_OVERFLOW_EN
      ovf       <= 1'b0;
`endif
    end else if (!stall) begin
      out_valid <= valid_reg[NSEG-1];
      if (valid_reg[NSEG-1]) begin
        sum     <= p_reg[NSEG-1] ^ carry[WIDTH-1:0];
        cout    <= carry[WIDTH];
        tag_out <= tag_reg[NSEG-1];
`ifdef KS_OVERFLOW_EN
        ovf     <= carry[WIDTH-1] ^ carry[WIDTH];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight <= '0;
    end else if (in_xfer && !out_xfer) begin
      in_flight <= in_flight + CNT_W'(1);
    end else if (out_xfer && !in_xfer) begin
      in_flight <= in_flight - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Scoreboard bench: a 32-bit/REG_EVERY=2 instance plus a 13-bit/REG_EVERY=1
// instance fed the same accepted transactions; KS_OVERFLOW_EN also checks ovf.
module tb_ks_adder_pipe;

  localparam int W      = 32;
  localparam int TW     = 4;
  localparam int NSEG   = ks_adder_pkg::ks_nseg(W, 2);
  localparam int LAT    = NSEG + 1;
  localparam int CW     = $clog2(NSEG + 2);
  localparam int W13    = 13;
  localparam int NSEG13 = ks_adder_pkg::ks_nseg(W13, 1);
  localparam int CW13   = $clog2(NSEG13 + 2);

  typedef struct packed {
    logic [31:0]   sum;
    logic          cout;
    logic          ovf;
    logic [TW-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic cin = 1'b0, op_sub = 1'b0;
  logic [TW-1:0] tag_in = '0;
  logic out_ready_drv = 1'b1, bp_en = 1'b0, bp_rand = 1'b1;
  logic out_ready;
  logic in_ready, out_valid, cout, ovf;
  logic [W-1:0] sum;
  logic [TW-1:0] tag_out;
  logic [CW-1:0] in_flight;

  logic in_valid13, in_ready13, out_valid13, cout13, ovf13;
  logic [W13-1:0] sum13;
  logic [TW-1:0] tag_out13;
  logic [CW13-1:0] in_flight13;

  int n_asserts = 0;
  int n_fail = 0;
  exp_t q32[$];
  exp_t q13[$];
  logic hold_v = 1'b0;
  logic [W+TW:0] held = '0;

  always #5 clk = ~clk;
  always @(posedge clk) #1 bp_rand = 1'($urandom_range(0, 1));
  assign out_ready  = bp_en ? bp_rand : out_ready_drv;
  assign in_valid13 = in_valid & in_ready;

  ks_adder_pipe #(.WIDTH(W), .REG_EVERY(2), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op_sub(op_sub), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .tag_out(tag_out), .in_flight(in_flight)
`ifdef KS_OVERFLOW_EN
    , .ovf(ovf)
`endif
  );

  ks_adder_pipe #(.WIDTH(W13), .REG_EVERY(1), .TAG_W(TW)) dut13 (
    .clk(clk), .rst(rst), .in_valid(in_valid13), .in_ready(in_ready13),
    .a(a[W13-1:0]), .b(b[W13-1:0]), .cin(cin), .op_sub(op_sub), .tag_in(tag_in),
    .out_valid(out_valid13), .out_ready(1'b1), .sum(sum13), .cout(cout13),
    .tag_out(tag_out13), .in_flight(in_flight13)
`ifdef KS_OVERFLOW_EN
    , .ovf(ovf13)
`endif
  );

`ifndef KS_OVERFLOW_EN
  assign ovf   = 1'b0;
  assign ovf13 = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Reference: plain wide addition, overflow from operand/result sign bits.
  function automatic exp_t model(input int w, input logic [31:0] aa, input logic [31:0] bb,
                                 input logic ci, input logic sub, input logic [TW-1:0] t);
    exp_t r;
    logic [31:0] mask, am, be;
    logic [32:0] full;
    mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    am    = aa & mask;
    be    = (sub ? ~bb : bb) & mask;
    full  = {1'b0, am} + {1'b0, be} + {32'd0, (sub | ci)};
    r.sum  = full[31:0] & mask;
    r.cout = full[w];
    r.ovf  = (am[w-1] == be[w-1]) && (full[w-1] != am[w-1]);
    r.tag  = t;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q32.delete();
      hold_v = 1'b0;
    end else begin
      chk("in_flight", 64'(in_flight), 64'(q32.size()));
      if (hold_v) chk("held_output", 64'({sum, cout, tag_out}), 64'(held));
      hold_v = out_valid & ~out_ready;
      held   = {sum, cout, tag_out};
      if (out_valid && out_ready) begin
        if (q32.size() == 0) chk("spurious_out", 64'(out_valid), 64'(0));
        else begin
          exp_t e;
          e = q32.pop_front();
          chk("sum_cout_tag", 64'({sum, cout, tag_out}), 64'({e.sum, e.cout, e.tag}));
`ifdef KS_OVERFLOW_EN
          chk("ovf", 64'(ovf), 64'(e.ovf));
`endif
        end
      end
      if (in_valid && in_ready) q32.push_back(model(W, a, b, cin, op_sub, tag_in));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q13.delete();
    end else begin
      chk("in_flight13", 64'(in_flight13), 64'(q13.size()));
      if (out_valid13) begin
        if (q13.size() == 0) chk("spurious_out13", 64'(out_valid13), 64'(0));
        else begin
          exp_t e;
          e = q13.pop_front();
          chk("sum_cout_tag13", 64'({sum13, cout13, tag_out13}),
              64'({e.sum[W13-1:0], e.cout, e.tag}));
`ifdef KS_OVERFLOW_EN
          chk("ovf13", 64'(ovf13), 64'(e.ovf));
`endif
        end
      end
      if (in_valid13) begin
        chk("in_ready13", 64'(in_ready13), 64'(1));
        q13.push_back(model(W13, a, b, cin, op_sub, tag_in));
      end
    end
  end

  task automatic send(input logic [31:0] aa, input logic [31:0] bb, input logic ci,
                      input logic sub, input logic [TW-1:0] t);
    int waited;
    @(posedge clk); #1;
    in_valid = 1'b1; a = aa; b = bb; cin = ci; op_sub = sub; tag_in = t;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    chk("accept", 64'(in_ready), 64'(1));
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q32.size() != 0 || q13.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain32", 64'(q32.size()), 64'(0));
    chk("drain13", 64'(q13.size()), 64'(0));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'hFFFF_FFFF;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_1FFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_flight", 64'(in_flight), 64'(0));
    chk("rst_outputs", 64'({sum, cout, tag_out}), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    // Carry ripples through every bit; also measures latency.
    send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 4'd5);
    idle();
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      chk("latency", 64'(out_valid), 64'(k == LAT));
    end
    chk("wrap_sum", 64'(sum), 64'(0));
    chk("wrap_cout", 64'(cout), 64'(1));
    chk("wrap_tag", 64'(tag_out), 64'(5));
    drain();

    send(32'd10, 32'd3, 1'b0, 1'b1, 4'd1);
    send(32'd3, 32'd10, 1'b1, 1'b1, 4'd2);
    send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 4'd3);
    send(32'h8000_0000, 32'd1, 1'b0, 1'b1, 4'd4);
    idle();
    drain();

    // Reset with three transactions in flight.
    for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0, 1'b0, 4'(i));
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("pre_rst_in_flight", 64'(in_flight), 64'(3));
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_in_flight", 64'(in_flight), 64'(0));
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      chk("post_rst_no_output", 64'(out_valid), 64'(0));
    end

    for (int i = 0; i < 100; i++)
      send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(i));
    idle();
    drain();

    // Fill the pipe against a stalled sink, then release.
    out_ready_drv = 1'b0;
    for (int i = 0; i < NSEG + 1; i++) send($urandom, $urandom, 1'b1, 1'b0, 4'(8 + i));
    @(posedge clk); #1;
    a = 32'd77; b = 32'd23; cin = 1'b0; op_sub = 1'b0; tag_in = 4'hC;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      chk("stall_in_flight", 64'(in_flight), 64'(NSEG + 1));
      chk("stall_out_valid", 64'(out_valid), 64'(1));
    end
    @(posedge clk); #1 out_ready_drv = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 64'(in_ready), 64'(1));
    idle();
    drain();

    bp_en = 1'b1;
    for (int i = 0; i < 60; i++)
      send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(i));
    idle();
    bp_en = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
